flit_perm_net: RTL and testbench



---
 rtl/flit_perm_pkg.sv | 25 ++
 rtl/perm_arb_2x2.sv | 46 ++++
 rtl/flit_perm_net.sv | 65 ++++++
 tb/tb_flit_perm_net.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/flit_perm_pkg.sv
// flit_perm_pkg: flit field offsets, stage count and golden-flit test shared by the permutation network
package flit_perm_pkg;
  localparam int FLIT_MAX = 64;
  localparam int PID_MAX = 16;
  function automatic int valid_bit(int flit_w);
    return flit_w - 1;
  endfunction
  function automatic int dest_lsb(int flit_w, int dest_w);
    return flit_w - 1 - dest_w;
  endfunction
  function automatic int pid_lsb(int flit_w, int dest_w, int pid_w);
    return flit_w - 1 - dest_w - pid_w;
  endfunction
  function automatic int num_stages(int num_ports);
    return $clog2(num_ports);
  endfunction
  function automatic logic flit_is_golden(logic [FLIT_MAX-1:0] flit, logic [PID_MAX-1:0] gid,
                                          int flit_w, int pid_lsb_i, int pid_w);
    logic [FLIT_MAX-1:0] v;
    logic [PID_MAX-1:0] m;
    v = flit >> valid_bit(flit_w);
    m = PID_MAX'((32'd1 << pid_w) - 32'd1);
    return v[0] && ((PID_MAX'(flit >> pid_lsb_i) & m) == (gid & m));
  endfunction
endpackage

// File: rtl/perm_arb_2x2.sv
// perm_arb_2x2: registered 2x2 deflection arbiter (golden priority, own round-robin tie_ptr)
module perm_arb_2x2
  import flit_perm_pkg::*;
#(
  parameter int FLIT_W = 10,
  parameter int DEST_W = 3,
  parameter int PID_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [3:0] bit_idx,
  input  logic [PID_W-1:0] golden_id,
  input  logic [FLIT_W-1:0] in_lo,
  input  logic [FLIT_W-1:0] in_hi,
  output logic [FLIT_W-1:0] out_lo,
  output logic [FLIT_W-1:0] out_hi
);
  localparam int DL = dest_lsb(FLIT_W, DEST_W);
  localparam int PL = pid_lsb(FLIT_W, DEST_W, PID_W);
  logic tie_ptr, va, vb, wa, wb, ga, gb, cont, a_wins, la, lb;
  logic [FLIT_W-1:0] nlo, nhi;
  always_comb begin
    va = in_lo[FLIT_W-1];
    vb = in_hi[FLIT_W-1];
    wa = 1'(in_lo >> (DL + int'(bit_idx)));
    wb = 1'(in_hi >> (DL + int'(bit_idx)));
    ga = flit_is_golden(FLIT_MAX'(in_lo), PID_MAX'(golden_id), FLIT_W, PL, PID_W);
    gb = flit_is_golden(FLIT_MAX'(in_hi), PID_MAX'(golden_id), FLIT_W, PL, PID_W);
    cont = va && vb && (wa == wb);
    a_wins = (ga != gb) ? ga : !tie_ptr;
    la = (cont && !a_wins) ? !wa : wa;
    lb = (cont && a_wins) ? !wb : wb;
    nlo = (va && !la) ? in_lo : (vb && !lb) ? in_hi : '0;
    nhi = (va && la) ? in_lo : (vb && lb) ? in_hi : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_lo <= '0;
      out_hi <= '0;
      tie_ptr <= 1'b0;
    end else begin
      out_lo <= nlo;
      out_hi <= nhi;
      if (cont && ga == gb) tie_ptr <= !tie_ptr;
    end
endmodule

// File: rtl/flit_perm_net.sv
// flit_perm_net: pipelined deflection permutation network, log2(NUM_PORTS) arbiter stages; FLIT_PERM_STATS_EN adds defl_cnt
module flit_perm_net
  import flit_perm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int FLIT_W = 10,
  parameter int DEST_W = 3,
  parameter int PID_W = 2,
  parameter int GOLDEN_EPOCH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_in,
  output logic [NUM_PORTS*FLIT_W-1:0] flit_out,
`ifdef FLIT_PERM_STATS_EN
  output logic [NUM_PORTS*16-1:0] defl_cnt,
`endif
  output logic [PID_W-1:0] golden_id
);
  localparam int S = num_stages(NUM_PORTS);
  localparam int LW = NUM_PORTS * FLIT_W;
  localparam int EW = GOLDEN_EPOCH > 1 ? $clog2(GOLDEN_EPOCH) : 1;
  logic [EW-1:0] epoch_cnt;
  logic [(S+1)*LW-1:0] stg;
  assign stg[LW-1:0] = flit_in;
  assign flit_out = stg[S*LW +: LW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      epoch_cnt <= '0;
      golden_id <= '0;
    end else if (epoch_cnt == EW'(GOLDEN_EPOCH - 1)) begin
      epoch_cnt <= '0;
      golden_id <= golden_id + PID_W'(1);
    end else
      epoch_cnt <= epoch_cnt + EW'(1);
  for (genvar s = 0; s < S; s++) begin : g_stage
    for (genvar p = 0; p < NUM_PORTS/2; p++) begin : g_arb
      localparam int B = S - 1 - s;
      localparam int LO = ((p >> B) << (B + 1)) | (p & ((1 << B) - 1));
      localparam int HI = LO | (1 << B);
      perm_arb_2x2 #(.FLIT_W(FLIT_W), .DEST_W(DEST_W), .PID_W(PID_W)) u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .bit_idx(4'(B)),
        .golden_id(golden_id),
        .in_lo(stg[s*LW + LO*FLIT_W +: FLIT_W]),
        .in_hi(stg[s*LW + HI*FLIT_W +: FLIT_W]),
        .out_lo(stg[(s+1)*LW + LO*FLIT_W +: FLIT_W]),
        .out_hi(stg[(s+1)*LW + HI*FLIT_W +: FLIT_W])
      );
    end
  end
`ifdef FLIT_PERM_STATS_EN
  localparam int DL = dest_lsb(FLIT_W, DEST_W);
  logic [NUM_PORTS-1:0] defl;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_defl
    assign defl[i] = flit_out[i*FLIT_W + FLIT_W - 1] && (flit_out[i*FLIT_W + DL +: S] != S'(i));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) defl_cnt <= '0;
    else
      for (int i = 0; i < NUM_PORTS; i++)
        if (defl[i] && defl_cnt[i*16 +: 16] != 16'hffff) defl_cnt[i*16 +: 16] <= defl_cnt[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_flit_perm_net.sv
// tb_flit_perm_net: randomized scoreboard bench for flit_perm_net against a lane-level arbitration model
module tb_flit_perm_net;
  localparam int NP = 4, FW = 10, DW = 3, PW = 2, EP = 4;
  localparam int S = $clog2(NP), W = NP * FW, DL = FW - 1 - DW, PL = DL - PW;
  typedef struct {
    int at;
    logic [W-1:0] exp;
    int nv;
  } ent_t;
  logic clk = 1'b0, rst_n;
  logic [W-1:0] flit_in, flit_out;
  logic [PW-1:0] golden_id;
`ifdef FLIT_PERM_STATS_EN
  logic [NP*16-1:0] defl_cnt;
  int exp_defl [NP];
`endif
  int compared = 0, mismatched = 0, cyc = 0;
  ent_t q[$];
  bit tie [S][NP];

  flit_perm_net #(.NUM_PORTS(NP), .FLIT_W(FW), .DEST_W(DW), .PID_W(PW), .GOLDEN_EPOCH(EP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flit_in(flit_in),
    .flit_out(flit_out),
`ifdef FLIT_PERM_STATS_EN
    .defl_cnt(defl_cnt),
`endif
    .golden_id(golden_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int nvalid(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(v[i*FW + FW - 1]);
    return n;
  endfunction

  function automatic bit wants_hi(input logic [FW-1:0] f, input int b);
    logic [FW-1:0] t;
    t = f >> (DL + b);
    return t[0];
  endfunction

  function automatic int pid_of(input logic [FW-1:0] f);
    return int'(f[PL +: PW]);
  endfunction

  function automatic logic [FW-1:0] mk(input bit v, input int dest, input int pid, input int pay);
    return {v, DW'(dest), PW'(pid), PL'(pay)};
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] v, input int k);
    logic [FW-1:0] cur [NP];
    logic [FW-1:0] nxt [NP];
    logic [W-1:0] r;
    int b, g, hi, wl, wh;
    bit vl, vh, gl, gh, lw;
    for (int i = 0; i < NP; i++) cur[i] = v[i*FW +: FW];
    for (int s = 0; s < S; s++) begin
      b = S - 1 - s;
      g = ((k + s - 1) / EP) % (1 << PW);
      for (int i = 0; i < NP; i++) nxt[i] = '0;
      for (int lo = 0; lo < NP; lo++) begin
        if ((lo & (1 << b)) != 0) continue;
        hi = lo | (1 << b);
        wl = wants_hi(cur[lo], b) ? hi : lo;
        wh = wants_hi(cur[hi], b) ? hi : lo;
        vl = cur[lo][FW-1];
        vh = cur[hi][FW-1];
        if (vl && vh && wl == wh) begin
          gl = pid_of(cur[lo]) == g;
          gh = pid_of(cur[hi]) == g;
          lw = (gl != gh) ? gl : !tie[s][lo];
          if (gl == gh) tie[s][lo] = !tie[s][lo];
          nxt[wl] = lw ? cur[lo] : cur[hi];
          nxt[wl ^ (1 << b)] = lw ? cur[hi] : cur[lo];
        end else begin
          if (vl) nxt[wl] = cur[lo];
          if (vh) nxt[wh] = cur[hi];
        end
      end
      cur = nxt;
    end
    for (int i = 0; i < NP; i++) r[i*FW +: FW] = cur[i];
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] v, input bit use_d = 1'b0, input logic [W-1:0] d = '0);
    ent_t e;
    flit_in = v;
    e.at = cyc + S;
    e.exp = model(v, cyc + 1);
    if (use_d) e.exp = d;
    e.nv = nvalid(v);
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      chk("golden_id", 64'(golden_id), 64'((cyc / EP) % (1 << PW)));
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        chk("flit_out", 64'(flit_out), 64'(e.exp));
        chk("valid_count", 64'(nvalid(flit_out)), 64'(e.nv));
`ifdef FLIT_PERM_STATS_EN
        for (int i = 0; i < NP; i++)
          if (e.exp[i*FW + FW - 1] && int'(e.exp[i*FW + DL +: S]) != i) exp_defl[i]++;
`endif
      end else if (nvalid(flit_out) != 0)
        chk("stray_flit", 64'(flit_out), 64'(0));
    end
  end

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b1;
    flit_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_flit_out", 64'(flit_out), 64'(0));
    chk("reset_golden", 64'(golden_id), 64'(0));
`ifdef FLIT_PERM_STATS_EN
    for (int i = 0; i < NP; i++) chk("reset_defl", 64'(defl_cnt[i*16 +: 16]), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v = '0; v[0 +: FW] = 10'h293; v[2*FW +: FW] = 10'h2C5;
    drive(v, 1'b1, {10'h2C5, 10'h000, 10'h000, 10'h293});
    v = '0; v[0 +: FW] = 10'h291; v[2*FW +: FW] = 10'h292;
    drive(v, 1'b1, {10'h000, 10'h291, 10'h000, 10'h292});
    v = '0; v[0 +: FW] = 10'h293; v[2*FW +: FW] = 10'h294;
    drive(v, 1'b1, {10'h000, 10'h294, 10'h000, 10'h293});
    v = '0; v[FW +: FW] = 10'h29A;
    drive(v, 1'b1, {10'h000, 10'h29A, 10'h000, 10'h000});
    repeat (20) begin
      for (int i = 0; i < NP; i++) v[i*FW +: FW] = mk(1'b1, NP - 1 - i, $urandom_range(0, 3), $urandom_range(0, 15));
      drive(v);
    end
    repeat (300) begin
      for (int i = 0; i < NP; i++)
        v[i*FW +: FW] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
      drive(v);
    end
    repeat (18) drive('0);
    for (int i = 0; i < NP; i++) v[i*FW +: FW] = mk(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
    drive(v);
    rst_n = 1'b0;
    #1;
    chk("midreset_flit_out", 64'(flit_out), 64'(0));
    chk("midreset_golden", 64'(golden_id), 64'(0));
    q.delete();
    for (int s = 0; s < S; s++) for (int i = 0; i < NP; i++) tie[s][i] = 1'b0;
`ifdef FLIT_PERM_STATS_EN
    for (int i = 0; i < NP; i++) exp_defl[i] = 0;
`endif
    flit_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) drive('0);
    repeat (60) begin
      for (int i = 0; i < NP; i++)
        v[i*FW +: FW] = mk($urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
      drive(v);
    end
    flit_in = '0;
    repeat (S + 3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));
`ifdef FLIT_PERM_STATS_EN
    for (int i = 0; i < NP; i++) chk("defl_cnt", 64'(defl_cnt[i*16 +: 16]), 64'(exp_defl[i]));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
